wb_cfg_master: RTL and testbench
================================

WB_CFG_MASTER -- requirements
Module: wb_cfg_master

Interface
REQ-001 Parameter TIMEOUT, default 255: max bus cycles awaiting ack before abort; legal range 1..1023.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  block can accept a command.
REQ-006 cmd_we  input  1  1 = write, 0 = read.
REQ-007 cmd_adr  input  32  byte address.
REQ-008 cmd_dat  input  32  write data.
REQ-009 cmd_sel  input  4  byte lane enables.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  consumer takes response.
REQ-012 rsp_dat  output  32  read data; 0 for writes and timeouts.
REQ-013 rsp_err  output  1  1 = transaction timed out.
REQ-014 wbm_cyc_o, wbm_stb_o, wbm_we_o  output  1 each  Wishbone B4 classic master controls.
REQ-015 wbm_adr_o  output  32; wbm_dat_o  output  32; wbm_sel_o  output  4  registered bus fields.
REQ-016 wbm_ack_i  input  1; wbm_dat_i  input  32  slave response.

Function
REQ-017 FSM has exactly three states: IDLE, BUS, RESP.
REQ-018 cmd_ready SHALL be 1 only in IDLE (combinational from state).
REQ-019 IDLE: on cmd_valid=1, latch we/adr/dat/sel into bus output registers, clear timeout counter, go to BUS; cyc/stb high from the next cycle.
REQ-020 BUS: wbm_cyc_o=wbm_stb_o=1; bus fields held stable for the whole cycle.
REQ-021 BUS with wbm_ack_i=1: capture wbm_dat_i into rsp_dat if read (0 if write), rsp_err=0, drop cyc/stb, go to RESP; the ack cycle is the final cycle of cyc/stb.
REQ-022 BUS without ack: increment counter; when counter equals TIMEOUT-1 without ack, drop cyc/stb, rsp_dat=0, rsp_err=1, go to RESP (cyc/stb high exactly TIMEOUT cycles).
REQ-023 Ack on the same cycle the timeout would fire: ack wins, rsp_err=0.
REQ-024 RESP: rsp_valid=1, rsp_dat/rsp_err stable; on rsp_ready=1 go to IDLE; rsp_valid low next cycle.
REQ-025 wbm_ack_i outside BUS is ignored and SHALL NOT change any state.
REQ-026 Minimum command-to-command spacing is 3 cycles (IDLE, BUS, RESP) with zero-wait slave and rsp_ready tied high.
REQ-027 Counter width is ceil(log2(TIMEOUT+1)); it SHALL NOT wrap within a transaction.

Reset
REQ-028 rst_n low: state=IDLE immediately; cyc/stb/we=0, adr/dat_o=0, sel=0, rsp_valid=0, rsp_dat=0, rsp_err=0, counter=0.
REQ-029 Reset asserted mid-BUS SHALL drop cyc/stb asynchronously; no response is produced for the aborted command.
REQ-030 First command is accepted on the first rising edge after rst_n deasserts.

Structure
REQ-031 Package wb_cfg_pkg holds the state encoding (IDLE=0, BUS=1, RESP=2) and default TIMEOUT constant.
REQ-032 Single module; no sub-module (the timeout counter is inline).

Verification
REQ-033 Write adr=0x3000_0000 dat=0x0000_0005 sel=0xF, slave acks after 2 wait cycles -> cyc/stb high 3 cycles, wbm_we_o=1, rsp_valid with rsp_dat=0, rsp_err=0.
REQ-034 Read adr=0x3000_0004, slave acks in first BUS cycle with 0xDEAD_BEEF -> rsp_dat=0xDEAD_BEEF, rsp_err=0, cmd_ready high again 3 cycles after acceptance.
REQ-035 TIMEOUT=4, slave never acks -> cyc/stb high exactly 4 cycles, rsp_err=1, rsp_dat=0.
REQ-036 TIMEOUT=4, ack in the 4th BUS cycle -> rsp_err=0, data captured.
REQ-037 rsp_ready held low 10 cycles -> rsp_valid/rsp_dat stable, cmd_ready=0, stray wbm_ack_i pulses ignored.
REQ-038 rst_n pulsed low in 2nd BUS cycle -> cyc/stb drop same cycle, no rsp_valid, next command runs normally.

Source files
------------

// File: rtl/wb_cfg_pkg.sv
// Shared definitions for the Wishbone configuration master.
//   - TimeoutDefault : default number of bus cycles to wait for ack before aborting
//   - state_e        : FSM state encoding (idle / bus cycle / response pending)
package wb_cfg_pkg;

  localparam int unsigned TimeoutDefault = 255;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/wb_cfg_master.sv
// Single-outstanding Wishbone B4 classic master driven by a valid/ready command port.
// Each command becomes one bus cycle. The cycle ends on ack or after TIMEOUT cycles,
// and the result is then held on the response port until it is consumed.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only while idle)
//   cmd_we/cmd_adr/cmd_dat/cmd_sel command fields, latched on acceptance
//   rsp_valid/rsp_ready            response handshake
//   rsp_dat/rsp_err                read data (0 for writes/timeouts), timeout flag
//   wbm_*_o                        registered Wishbone master outputs
//   wbm_ack_i/wbm_dat_i            Wishbone slave response
module wb_cfg_master
  import wb_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  // Wide enough to hold TIMEOUT itself; the counter never passes TIMEOUT-1.
  localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e          state;
  logic [CntW-1:0] tmo_cnt;

  assign cmd_ready = (state == StIdle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      tmo_cnt   <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            tmo_cnt   <= '0;
            state     <= StBus;
          end
        end
        StBus: begin
          // Ack takes priority over a timeout firing in the same cycle.
          if (wbm_ack_i) begin
            rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= StResp;
          end else if (tmo_cnt == CntLast) begin
            rsp_dat   <= 32'h0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= StResp;
          end else begin
            tmo_cnt <= tmo_cnt + CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cfg_master.sv
module tb_wb_cfg_master;

  localparam int To = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_cfg_master #(.TIMEOUT(To)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i)
  );

  // ack_dly: BUS cycle index (0-based) in which the slave acks, -1 = never.
  // hold: extra RESP cycles with rsp_ready low.
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          ack_dly;
    logic [31:0] rdat;
    int          hold;
    int          exp_cyc;
    logic [31:0] exp_dat;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: bus cycle length, response and command-to-ready latency from the rules.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit   acked = (v.ack_dly >= 0) && (v.ack_dly < To);
    r.exp_cyc = acked ? v.ack_dly + 1 : To;
    r.exp_err = !acked;
    r.exp_dat = (acked && !v.we) ? v.rdat : 32'h0;
    r.exp_lat = r.exp_cyc + v.hold + 2;
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic run_txn(input vec_t v, input string tag);
    int          k;
    int          lat;
    bit          bus_ok;
    bit          resp_ok;
    logic [31:0] r_dat;
    logic        r_err;
    chk({tag, ".cmd_ready_idle"}, {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_adr   = v.adr;
    cmd_dat   = v.dat;
    cmd_sel   = v.sel;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_we    = $urandom;
    cmd_adr   = $urandom;
    cmd_dat   = $urandom;
    cmd_sel   = 4'($urandom);
    lat    = 1;
    k      = 0;
    bus_ok = 1'b1;
    while (wbm_cyc_o && k < 64) begin
      if (!wbm_stb_o || wbm_we_o !== v.we || wbm_adr_o !== v.adr || wbm_dat_o !== v.dat ||
          wbm_sel_o !== v.sel || cmd_ready || rsp_valid)
        bus_ok = 1'b0;
      wbm_ack_i = (k == v.ack_dly);
      wbm_dat_i = wbm_ack_i ? v.rdat : $urandom;
      @(posedge clk);
      @(negedge clk);
      wbm_ack_i = 1'b0;
      k++;
      lat++;
    end
    chk({tag, ".bus_fields"}, {31'b0, bus_ok}, 32'd1);
    chk({tag, ".cyc_cycles"}, k, v.exp_cyc);
    chk({tag, ".stb_low"}, {31'b0, wbm_stb_o}, 32'd0);
    chk({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({tag, ".rsp_dat"}, rsp_dat, v.exp_dat);
    chk({tag, ".rsp_err"}, {31'b0, rsp_err}, {31'b0, v.exp_err});
    r_dat     = rsp_dat;
    r_err     = rsp_err;
    rsp_ready = (v.hold == 0);
    resp_ok   = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      // Stray acks while a response is pending must be ignored.
      wbm_ack_i = $urandom;
      wbm_dat_i = $urandom;
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (!rsp_valid || rsp_dat !== r_dat || rsp_err !== r_err || cmd_ready || wbm_cyc_o)
        resp_ok = 1'b0;
      if (h == v.hold - 1) begin
        wbm_ack_i = 1'b0;
        rsp_ready = 1'b1;
      end
    end
    if (v.hold > 0) chk({tag, ".resp_stable"}, {31'b0, resp_ok}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    lat++;
    rsp_ready = 1'b0;
    chk({tag, ".rsp_valid_drop"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, ".ready_lat"}, (cmd_ready === 1'b1) ? lat : -1, v.exp_lat);
  endtask

  initial begin
    vec_t rv;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;

    //            we    adr           dat           sel   ack rdat          hold cyc exp_dat     err lat
    vecs[0] = '{1'b1, 32'h3000_0000, 32'h0000_0005, 4'hF, 2, 32'h1234_5678, 0, 3, 32'h0,        0, 5};
    vecs[1] = '{1'b0, 32'h3000_0004, 32'h0,         4'hF, 0, 32'hDEAD_BEEF, 0, 1, 32'hDEAD_BEEF, 0, 3};
    vecs[2] = '{1'b0, 32'h3000_0008, 32'h0,         4'hF, -1, 32'h5555_AAAA, 0, 4, 32'h0,       1, 6};
    vecs[3] = '{1'b0, 32'h3000_000C, 32'h0,         4'h3, 3, 32'hCAFE_F00D, 0, 4, 32'hCAFE_F00D, 0, 6};
    vecs[4] = '{1'b1, 32'h3000_0010, 32'hFFFF_0000, 4'hC, -1, 32'h0,        0, 4, 32'h0,        1, 6};
    vecs[5] = '{1'b0, 32'h3000_0014, 32'h0,         4'h1, 1, 32'hA5A5_5A5A, 10, 2, 32'hA5A5_5A5A, 0, 14};

    // Reset state, with a stray ack that must not matter.
    wbm_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.cyc", {31'b0, wbm_cyc_o}, 32'd0);
    chk("rst.stb", {31'b0, wbm_stb_o}, 32'd0);
    chk("rst.we", {31'b0, wbm_we_o}, 32'd0);
    chk("rst.adr", wbm_adr_o, 32'd0);
    chk("rst.dat_o", wbm_dat_o, 32'd0);
    chk("rst.sel", {28'b0, wbm_sel_o}, 32'd0);
    chk("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst.rsp_dat", rsp_dat, 32'd0);
    chk("rst.rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst.cmd_ready", {31'b0, cmd_ready}, 32'd1);
    wbm_ack_i = 1'b0;
    rst_n     = 1'b1;

    // First command issued right after reset release.
    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Acks while idle must not start a cycle or a response.
    wbm_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    wbm_ack_i = 1'b0;
    chk("idle_ack.cyc", {31'b0, wbm_cyc_o}, 32'd0);
    chk("idle_ack.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("idle_ack.cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Reset in the 2nd BUS cycle: bus drops asynchronously, no response follows.
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h3000_0020;
    cmd_sel   = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.cyc_before", {31'b0, wbm_cyc_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.cyc_async", {31'b0, wbm_cyc_o}, 32'd0);
    chk("midrst.stb_async", {31'b0, wbm_stb_o}, 32'd0);
    chk("midrst.cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst.no_rsp", {31'b0, rsp_valid}, 32'd0);
    run_txn(vecs[1], "post_rst");

    // Randomized transactions against the reference model.
    for (int i = 0; i < 40; i++) begin
      rv.we      = $urandom;
      rv.adr     = $urandom;
      rv.dat     = $urandom;
      rv.sel     = 4'($urandom);
      rv.ack_dly = int'($urandom_range(0, 5));
      if (rv.ack_dly == 5) rv.ack_dly = -1;
      rv.rdat    = $urandom;
      rv.hold    = int'($urandom_range(0, 3));
      rv = model(rv);
      run_txn(rv, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
